// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front-end blocks.
//   WORD_W        datapath / address width
//   INST_BYTES    bytes per instruction word (PC stride)
//   RESET_PC_DEF  default first fetch address
//   NOP           all-zero instruction word, also used as the FIFO reset value
package mips_pkg;

    localparam int WORD_W     = 32;
    localparam int INST_BYTES = 4;

    localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [WORD_W-1:0] NOP          = 32'h0000_0000;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    // Instruction addresses are always word aligned; the low two bits are dropped.
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Bus bundle between the fetch queue, instruction memory and decode.
//   imem_req_valid/addr/ready   fetch request handshake (fetch -> memory)
//   imem_resp_valid/data        in-order instruction responses (memory -> fetch)
//   out_valid/inst/pcplus4      head instruction presented to decode
//   out_ready                   decode consumes the head (IF/ID write enable)
// master: the fetch queue side; slave: memory + decode side.
interface inst_fetch_queue_if;
    import mips_pkg::*;

    logic              imem_req_valid;
    logic [WORD_W-1:0] imem_req_addr;
    logic              imem_req_ready;
    logic              imem_resp_valid;
    logic [WORD_W-1:0] imem_resp_data;
    logic              out_valid;
    logic [WORD_W-1:0] out_inst;
    logic [WORD_W-1:0] out_pcplus4;
    logic              out_ready;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        output out_valid, out_inst, out_pcplus4,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        input  out_valid, out_inst, out_pcplus4,
        output out_ready
    );

endinterface

// File: rtl/inst_fetch_queue_sync_fifo.sv
// Synchronous FIFO with flush, no bypass: a push is visible at the head
// one cycle later at the earliest.
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write an entry
//   pop             drop the head entry
//   flush           empty the FIFO; wins over push and pop
//   count           number of valid entries
//   head            entry at the head (meaningful while count != 0)
// DEPTH must be a power of two (pointers wrap naturally) and at least 2.
module sync_fifo #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push && !flush) mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (push && !pop && !flush) |-> (count_q != CW'(DEPTH)));

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        (pop && !flush) |-> (count_q != '0));

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end feeding the IF/ID register.
// Owns the fetch PC, issues word requests to instruction memory, buffers the
// returned words and presents them with PC+4 to decode. A redirect from ID
// flushes the buffer and marks in-flight requests to be dropped on return.
//   clk, reset       clock, asynchronous active-high reset
//   redirect_valid   taken branch/jump from ID
//   redirect_pc      redirect target (low two bits ignored)
//   bus              memory request/response and decode handshake (master side)
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_BOOT | single idle cycle after reset release, no requests
// ST_RUN  | normal fetching
module inst_fetch_queue
    import mips_pkg::*;
#(
    parameter int                DEPTH           = 4,
    parameter int                MAX_OUTSTANDING = 2,
    parameter logic [WORD_W-1:0] RESET_PC        = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [WORD_W-1:0]  redirect_pc,
    inst_fetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int OW = $clog2(MAX_OUTSTANDING+1);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_W-1:0] head_pc_q, head_pc_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic [OW-1:0]     drop_q, drop_d;

    logic [CW-1:0]     fifo_count;
    logic [WORD_W-1:0] fifo_head;
    logic [WORD_W-1:0] redirect_tgt;
    logic              credit_ok;
    logic              req_valid;
    logic              req_fire;
    logic              resp;
    logic              push;
    logic              pop;

    assign redirect_tgt = align_word(redirect_pc);

    // Buffered plus in-flight words may never exceed the FIFO size, so every
    // accepted request is guaranteed a slot when its response returns.
    assign credit_ok = (32'(fifo_count) + 32'(outst_q)) < 32'(DEPTH);
    assign req_valid = (state_q == ST_RUN) && !redirect_valid && credit_ok
                       && (32'(outst_q) < 32'(MAX_OUTSTANDING));
    assign req_fire  = req_valid && bus.imem_req_ready;
    assign resp      = bus.imem_resp_valid;

    // Responses to requests issued before a redirect are discarded while
    // drop_q is non-zero; in-order return keeps them ahead of new ones.
    assign push = resp && (drop_q == '0) && !redirect_valid;
    assign pop  = (fifo_count != '0) && bus.out_ready && !redirect_valid;

    sync_fifo #(
        .WIDTH    (WORD_W),
        .DEPTH    (DEPTH),
        .RESET_VAL(NOP)
    ) u_fifo (
        .clk      (clk),
        .rst      (reset),
        .push     (push),
        .push_data(bus.imem_resp_data),
        .pop      (pop),
        .flush    (redirect_valid),
        .count    (fifo_count),
        .head     (fifo_head)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        outst_d    = outst_q + OW'(req_fire) - OW'(resp);
        drop_d     = drop_q;
        if (redirect_valid) begin
            // No request can fire in a redirect cycle, so outst_d is just
            // the old count less this cycle's response: all of it is stale.
            fetch_pc_d = redirect_tgt;
            head_pc_d  = redirect_tgt;
            drop_d     = outst_q - OW'(resp);
        end else begin
            if (pop)      head_pc_d  = head_pc_q + 32'(INST_BYTES);
            if (req_fire) fetch_pc_d = fetch_pc_q + 32'(INST_BYTES);
            if (resp && (drop_q != '0)) drop_d = drop_q - OW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.out_valid      = (fifo_count != '0);
    assign bus.out_inst       = fifo_head;
    assign bus.out_pcplus4    = head_pc_q + 32'(INST_BYTES);

    a_resp_protocol: assert property (@(posedge clk) disable iff (reset)
        bus.imem_resp_valid |-> (outst_q != '0));

    a_outst_bound: assert property (@(posedge clk) disable iff (reset)
        32'(outst_q) <= 32'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    inst_fetch_queue_if bus();

    inst_fetch_queue #(
        .DEPTH(4),
        .MAX_OUTSTANDING(2),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .bus           (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: in-flight requests as a queue of addresses (stale flag
    // set by a redirect), decode buffer as a queue of word addresses.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] m_fetch_pc;
    bit          m_boot;
    int          cyc = 0;
    int          lat_min = 1, lat_max = 1;

    bit          p_ready = 1, p_oready = 1, p_redir = 0;
    logic [31:0] p_rpc = '0;
    bit          s_out_valid;
    logic [31:0] s_pcp4;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        mem_q.delete();
        fifo_q.delete();
        m_fetch_pc = 32'h0000_0000;
        m_boot     = 1'b1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_inst",  bus.out_inst, 32'd0);
        chk("rst_pcplus4",   bus.out_pcplus4, 32'd4);
    endtask

    task automatic step(input bit rst_mid);
        bit exp_req, fire, resp, pop;
        int c;
        if (1) begin
            @(negedge clk);
            if (reset) reset = 1'b0;
            redirect_valid     = p_redir;
            redirect_pc        = p_rpc;
            bus.imem_req_ready = p_ready;
            bus.out_ready      = p_oready;
            resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
            bus.imem_resp_valid = resp;
            bus.imem_resp_data  = resp ? mem_word(mem_q[0].addr) : $urandom;
            #1;
            exp_req = !m_boot && !p_redir && (fifo_q.size() + mem_q.size() < 4)
                      && (mem_q.size() < 2);
            chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
            if (exp_req) chk("req_addr", bus.imem_req_addr, m_fetch_pc);
            chk("out_valid", 32'(bus.out_valid), 32'(fifo_q.size() != 0));
            if (fifo_q.size() != 0) begin
                chk("out_inst", bus.out_inst, mem_word(fifo_q[0]));
                chk("out_pcplus4", bus.out_pcplus4, fifo_q[0] + 32'd4);
            end
            s_out_valid = bus.out_valid;
            s_pcp4      = bus.out_pcplus4;
            if (rst_mid) begin
                reset = 1'b1;
                bus.imem_resp_valid = 1'b0;
                #1;
                chk_reset_outputs();
                model_reset();
                @(posedge clk);
                cyc++;
                return;
            end
            fire = exp_req && p_ready;
            pop  = (fifo_q.size() != 0) && p_oready && !p_redir;
            c = cyc;
            @(posedge clk);
            cyc++;
            if (resp) begin
                mreq_t e;
                e = mem_q.pop_front();
                if (!e.stale && !p_redir) fifo_q.push_back(e.addr);
            end
            if (p_redir) begin
                fifo_q.delete();
                foreach (mem_q[i]) mem_q[i].stale = 1'b1;
                m_fetch_pc = {p_rpc[31:2], 2'b00};
            end else begin
                if (pop) void'(fifo_q.pop_front());
                if (fire) begin
                    mem_q.push_back('{addr: m_fetch_pc,
                                      due: c + int'($urandom_range(lat_max, lat_min)),
                                      stale: 1'b0});
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
            m_boot = 1'b0;
        end
    endtask

    initial begin
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.out_ready       = 1'b1;
        model_reset();
        #1;
        chk_reset_outputs();

        // 1-cycle memory, everything ready: one instruction per cycle
        lat_min = 1; lat_max = 1;
        repeat (30) step(0);

        // decode stalled, then drained
        p_oready = 0;
        repeat (10) step(0);
        chk("stall_fifo_full", 32'(bus.out_valid), 32'd1);
        p_oready = 1;
        repeat (20) step(0);

        // 3-cycle memory, random decode stalls
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 40; i++) begin
            p_oready = ($urandom_range(0, 3) != 0);
            step(0);
        end

        // redirect while words are buffered and requests are in flight
        p_oready = 0;
        for (int i = 0; i < 40 && !(fifo_q.size() >= 1 && mem_q.size() >= 1); i++) step(0);
        p_redir = 1; p_rpc = 32'h0000_0103;
        step(0);
        p_redir = 0; p_oready = 1;
        step(0);
        chk("post_redir_valid", 32'(s_out_valid), 32'd0);
        for (int i = 0; i < 20 && !s_out_valid; i++) step(0);
        chk("redir_out_valid", 32'(s_out_valid), 32'd1);
        if (s_out_valid) chk("redir_pcplus4", s_pcp4, 32'h0000_0104);

        // asynchronous reset mid-burst
        lat_min = 1; lat_max = 1;
        repeat (6) step(0);
        step(1);
        repeat (8) step(0);

        // randomized mix
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            p_ready  = ($urandom_range(0, 3) != 0);
            p_oready = ($urandom_range(0, 9) < 7);
            p_redir  = ($urandom_range(0, 19) == 0);
            p_rpc    = $urandom;
            step($urandom_range(0, 299) == 0);
        end
        p_redir = 0;
        repeat (10) step(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
